// File: rtl/dmem_arbiter_if.sv
// Bus bundle between dmem_arbiter, its two requesters and the single-port DMEM.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              dm_ena;
    logic              dm_w;
    logic              dm_r;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  dm_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output dm_ena, dm_w, dm_r, dm_addr, dm_wdata,
        output busy, owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output dm_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  dm_ena, dm_w, dm_r, dm_addr, dm_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DMEM: IDLE -> ACCESS -> DONE per word.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic              lat_we;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection; only consulted in IDLE when at least one port requests.
    always_comb begin
        grant = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
            grant = ~bus.owner;
`else
            grant = 1'b0;
`endif
        end else if (bus.m1_req) begin
            grant = 1'b1;
        end
        sel_we    = grant ? bus.m1_we    : bus.m0_we;
        sel_addr  = grant ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = grant ? bus.m1_wdata : bus.m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
            bus.dm_ena   <= 1'b0;
            bus.dm_w     <= 1'b0;
            bus.dm_r     <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            bus.busy     <= 1'b0;
            bus.owner    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    if (bus.m0_req || bus.m1_req) begin
                        state        <= ACCESS;
                        bus.owner    <= grant;
                        lat_we       <= sel_we;
                        bus.dm_ena   <= 1'b1;
                        bus.dm_w     <= sel_we;
                        bus.dm_r     <= ~sel_we;
                        bus.dm_addr  <= sel_addr;
                        bus.dm_wdata <= sel_wdata;
                        bus.busy     <= 1'b1;
                    end
                end
                ACCESS: begin
                    // dm_rdata is combinational from the latched address, so it is valid here.
                    if (!lat_we) begin
                        if (bus.owner) bus.m1_rdata <= bus.dm_rdata;
                        else           bus.m0_rdata <= bus.dm_rdata;
                    end
                    bus.dm_ena <= 1'b0;
                    bus.dm_w   <= 1'b0;
                    bus.dm_r   <= 1'b0;
                    bus.m0_ack <= ~bus.owner;
                    bus.m1_ack <= bus.owner;
                    state      <= DONE;
                end
                DONE: begin
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes expected DMEM accesses and acks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural DMEM: combinational read, write committed on the falling edge.
    bit [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    assign bus.dm_rdata = mem[bus.dm_addr];
    always @(negedge clk) begin
        if (bus.dm_ena && bus.dm_w) mem[bus.dm_addr] <= bus.dm_wdata;
    end

    typedef struct {
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    typedef struct {
        bit                port;
        logic [DATA_W-1:0] rdata;
        int                gap;
    } ack_t;

    acc_t acc_q[$];
    ack_t ack_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last_ack [2];
    bit mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic pushAcc(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata;
        acc_q.push_back(a);
    endtask

    task automatic pushAck(input bit port, input logic [DATA_W-1:0] rdata, input int gap);
        ack_t k;
        k.port = port; k.rdata = rdata; k.gap = gap;
        ack_q.push_back(k);
    endtask

    task automatic applyStimulus(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        if (port) begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
        end else begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
        end
    endtask

    task automatic dropReq(input bit port);
        if (port) bus.m1_req = 1'b0;
        else      bus.m0_req = 1'b0;
    endtask

    task automatic waitAck(input bit port, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? bus.m1_ack : bus.m0_ack) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        checkOutput(port ? "ack_seen_p1" : "ack_seen_p0", 64'(seen), 64'(1));
    endtask

    task automatic doTxn(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                         input bit chk_lat);
        int lat;
        pushAcc(we, addr, wdata);
        pushAck(port, exp_rdata, 0);
        applyStimulus(port, we, addr, wdata);
        waitAck(port, lat);
        if (chk_lat) checkOutput("ack_latency", 64'(lat), 64'(2));
        @(posedge clk);
        #1 dropReq(port);
    endtask

    // Monitor: every DMEM access and every ack must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.dm_ena) begin
                checkOutput("acc_pending", 64'(acc_q.size() != 0), 64'(1));
                if (acc_q.size() != 0) begin
                    acc_t a;
                    a = acc_q.pop_front();
                    checkOutput("dm_w", 64'(bus.dm_w), 64'(a.we));
                    checkOutput("dm_r", 64'(bus.dm_r), 64'(!a.we));
                    checkOutput("dm_addr", 64'(bus.dm_addr), 64'(a.addr));
                    checkOutput("dm_wdata", 64'(bus.dm_wdata), 64'(a.wdata));
                end
            end
            if (bus.m0_ack || bus.m1_ack) begin
                checkOutput("ack_exclusive", 64'(bus.m0_ack && bus.m1_ack), 64'(0));
                checkOutput("ack_pending", 64'(ack_q.size() != 0), 64'(1));
                if (ack_q.size() != 0) begin
                    ack_t k;
                    k = ack_q.pop_front();
                    checkOutput("ack_port", 64'(bus.m1_ack), 64'(k.port));
                    checkOutput("ack_rdata", 64'(k.port ? bus.m1_rdata : bus.m0_rdata), 64'(k.rdata));
                    if (k.gap != 0) checkOutput("ack_gap", 64'(cyc - last_ack[k.port]), 64'(k.gap));
                    last_ack[k.port] = cyc;
                end
            end
        end
    end

    initial begin
        int lat;
        last_ack[0] = 0;
        last_ack[1] = 0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_m0_ack", 64'(bus.m0_ack), 64'(0));
        checkOutput("rst_m1_ack", 64'(bus.m1_ack), 64'(0));
        checkOutput("rst_m0_rdata", 64'(bus.m0_rdata), 64'(0));
        checkOutput("rst_m1_rdata", 64'(bus.m1_rdata), 64'(0));
        checkOutput("rst_dm_strobes", 64'({bus.dm_ena, bus.dm_w, bus.dm_r}), 64'(0));
        checkOutput("rst_dm_addr", 64'(bus.dm_addr), 64'(0));
        checkOutput("rst_dm_wdata", 64'(bus.dm_wdata), 64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_owner", 64'(bus.owner), 64'(1));
        mon_en = 1'b1;

        $display("[TB] single-port writes and reads");
        doTxn(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, 32'h0, 1'b1);
        checkOutput("owner_after_p0", 64'(bus.owner), 64'(0));
        doTxn(1'b1, 1'b1, 11'd6, 32'h12345678, 32'h0, 1'b1);
        doTxn(1'b1, 1'b0, 11'd5, 32'h0, 32'hDEADBEEF, 1'b1);
        checkOutput("m0_rdata_unchanged", 64'(bus.m0_rdata), 64'(0));
        checkOutput("owner_after_p1", 64'(bus.owner), 64'(1));

        $display("[TB] address change during ACCESS");
        pushAcc(1'b0, 11'd5, 32'h0);
        pushAck(1'b1, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 1'b0, 11'd5, 32'h0);
        @(posedge clk);
        #1 bus.m1_addr = 11'd6;
        checkOutput("busy_in_access", 64'(bus.busy), 64'(1));
        waitAck(1'b1, lat);
        @(posedge clk);
        #1 dropReq(1'b1);

        doTxn(1'b0, 1'b0, 11'd6, 32'h0, 32'h12345678, 1'b1);
        checkOutput("m1_rdata_held", 64'(bus.m1_rdata), 64'(32'hDEADBEEF));

        $display("[TB] request held across ack");
        pushAcc(1'b0, 11'd5, 32'h0);
        pushAcc(1'b0, 11'd5, 32'h0);
        pushAck(1'b0, 32'hDEADBEEF, 0);
        pushAck(1'b0, 32'hDEADBEEF, 3);
        applyStimulus(1'b0, 1'b0, 11'd5, 32'h0);
        waitAck(1'b0, lat);
        waitAck(1'b0, lat);
        @(posedge clk);
        #1 dropReq(1'b0);

        $display("[TB] reset during ACCESS");
        @(posedge clk);
        pushAcc(1'b0, 11'd6, 32'h0);
        #1 applyStimulus(1'b0, 1'b0, 11'd6, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        dropReq(1'b0);
        checkOutput("mid_rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("mid_rst_m0_ack", 64'(bus.m0_ack), 64'(0));
        checkOutput("mid_rst_m0_rdata", 64'(bus.m0_rdata), 64'(0));
        checkOutput("mid_rst_strobes", 64'({bus.dm_ena, bus.dm_w, bus.dm_r}), 64'(0));
        checkOutput("mid_rst_owner", 64'(bus.owner), 64'(1));
        repeat (4) @(negedge clk);

        $display("[TB] continuous contention");
`ifdef DMEM_ARB_RR_EN
        pushAcc(1'b0, 11'd5, 32'h0);
        pushAcc(1'b0, 11'd6, 32'h0);
        pushAcc(1'b0, 11'd5, 32'h0);
        pushAcc(1'b0, 11'd6, 32'h0);
        pushAck(1'b0, 32'hDEADBEEF, 0);
        pushAck(1'b1, 32'h12345678, 0);
        pushAck(1'b0, 32'hDEADBEEF, 6);
        pushAck(1'b1, 32'h12345678, 6);
`else
        for (int i = 0; i < 4; i++) begin
            pushAcc(1'b0, 11'd5, 32'h0);
            pushAck(1'b0, 32'hDEADBEEF, (i == 0) ? 0 : 3);
        end
`endif
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 11'd5, 32'h0);
        applyStimulus(1'b1, 1'b0, 11'd6, 32'h0);
        repeat (11) @(posedge clk);
        #1;
        dropReq(1'b0);
        dropReq(1'b1);
        repeat (6) @(negedge clk);

        checkOutput("ack_q_drained", 64'(ack_q.size()), 64'(0));
        checkOutput("acc_q_drained", 64'(acc_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
